// File: rtl/axistream_unpack_keep_pkg.sv
// Shared defaults and helpers for the keep-aware AXI-Stream unpacker.
package axistream_unpack_keep_pkg;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefNumPack   = 4;

   // Index width for an n-entry selector; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axistream_unpack_keep_if.sv
// Generic AXI-Stream bundle; KEEP_WIDTH is one per word on the bus.
interface axistream_unpack_keep_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned KEEP_WIDTH = 1
);

   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tlast;

   modport master (
      output tvalid,
      output tdata,
      output tkeep,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tkeep,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axistream_unpack_keep_lsb_onehot.sv
// Lowest-set-bit finder: one-hot, binary index and single-bit flag of a mask.
module lsb_onehot
   import axistream_unpack_keep_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]            mask_i,
   output logic [WIDTH-1:0]            onehot_o,
   output logic [idx_width(WIDTH)-1:0] index_o,
   output logic                        is_onehot_o
);

   localparam int unsigned IdxW = idx_width(WIDTH);

   // Isolate the lowest set bit and flag masks with exactly one bit set.
   always_comb begin
      onehot_o    = mask_i & (~mask_i + WIDTH'(1));
      is_onehot_o = (mask_i != '0) && ((mask_i & (mask_i - WIDTH'(1))) == '0);
   end

   // Scan from the top down so the lowest set bit wins.
   always_comb begin
      index_o = '0;
      for (int unsigned i = WIDTH; i > 0; i--) begin
         if (mask_i[i-1]) begin
            index_o = IdxW'(i - 1);
         end
      end
   end

endmodule

// File: rtl/axistream_unpack_keep.sv
// Width-down AXI-Stream converter: splits NUM_PACK-word beats into single words,
// emitting only kept words and placing tlast on the final kept word.
module axistream_unpack_keep
   import axistream_unpack_keep_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned NUM_PACK   = DefNumPack,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   axistream_unpack_keep_if.slave  src_io,
   axistream_unpack_keep_if.master dest_io,
   output logic                    drop_pulse_o
);

   localparam int unsigned IdxW = idx_width(NUM_PACK);

   logic [NUM_PACK-1:0][DATA_WIDTH-1:0] data_ord;
   logic [NUM_PACK-1:0][DATA_WIDTH-1:0] data_q;
   logic [NUM_PACK-1:0]                 keep_ord;
   logic [NUM_PACK-1:0]                 pend_q, pend_d;
   logic [NUM_PACK-1:0]                 cur_onehot;
   logic [IdxW-1:0]                     cur_idx;
   logic                                onehot_last;
   logic                                tlast_q, tlast_d;
   logic                                drop_q, drop_d;
   logic                                dest_valid;
   logic                                src_ready;
   logic                                src_hs;
   logic                                dest_hs;

   // Reorder words and keep bits so emit order always runs from index 0 upward.
   for (genvar g = 0; g < NUM_PACK; g++) begin : g_reorder
      localparam int unsigned Src = BIG_ENDIAN ? (NUM_PACK - 1 - g) : g;
      assign keep_ord[g] = src_io.tkeep[Src];
      assign data_ord[g] = src_io.tdata[Src*DATA_WIDTH +: DATA_WIDTH];
   end

   lsb_onehot #(
      .WIDTH (NUM_PACK)
   ) u_lsb_onehot (
      .mask_i      (pend_q),
      .onehot_o    (cur_onehot),
      .index_o     (cur_idx),
      .is_onehot_o (onehot_last)
   );

   // Handshakes; src_tready looks through to dest_tready so beats chain without a bubble.
   always_comb begin
      dest_valid = rst_n && (pend_q != '0);
      src_ready  = rst_n && ((pend_q == '0) || (dest_valid && dest_io.tready && onehot_last));
      src_hs     = src_ready && src_io.tvalid;
      dest_hs    = dest_valid && dest_io.tready;
   end

   // Outputs; tkeep on the narrow side is always full.
   always_comb begin
      src_io.tready  = src_ready;
      dest_io.tvalid = dest_valid;
      dest_io.tdata  = data_q[cur_idx];
      dest_io.tlast  = dest_valid && tlast_q && onehot_last;
      dest_io.tkeep  = '1;
      drop_pulse_o   = drop_q;
   end

   // Next state: a new beat load overrides the clear of the word just sent.
   always_comb begin
      pend_d  = pend_q;
      tlast_d = tlast_q;
      drop_d  = 1'b0;
      if (dest_hs) begin
         pend_d = pend_q & ~cur_onehot;
      end
      if (src_hs) begin
         pend_d  = keep_ord;
         tlast_d = src_io.tlast;
         drop_d  = (keep_ord == '0) && src_io.tlast;
      end
   end

   // Control state; reset discards any partially emitted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= '0;
         tlast_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         tlast_q <= tlast_d;
         drop_q  <= drop_d;
      end
   end

   // Beat data buffer; contents are only meaningful while pend is non-zero.
   always_ff @(posedge clk) begin
      if (src_hs) begin
         data_q <= data_ord;
      end
   end

endmodule

// File: tb/tb_axistream_unpack_keep.sv
// Directed bench: little- and big-endian unpackers driven with identical beats.
module tb_axistream_unpack_keep;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        src_tvalid;
   logic [31:0] src_tdata;
   logic [3:0]  src_tkeep;
   logic        src_tlast;
   logic        dest_tready;
   logic        drop0, drop1;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   axistream_unpack_keep_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) s0 ();
   axistream_unpack_keep_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1)) d0 ();
   axistream_unpack_keep_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) s1 ();
   axistream_unpack_keep_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1)) d1 ();

   assign s0.tvalid = src_tvalid;
   assign s0.tdata  = src_tdata;
   assign s0.tkeep  = src_tkeep;
   assign s0.tlast  = src_tlast;
   assign d0.tready = dest_tready;
   assign s1.tvalid = src_tvalid;
   assign s1.tdata  = src_tdata;
   assign s1.tkeep  = src_tkeep;
   assign s1.tlast  = src_tlast;
   assign d1.tready = dest_tready;

   axistream_unpack_keep #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b0)) u_dut_le (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_io       (s0),
      .dest_io      (d0),
      .drop_pulse_o (drop0)
   );

   axistream_unpack_keep #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b1)) u_dut_be (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_io       (s1),
      .dest_io      (d1),
      .drop_pulse_o (drop1)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Move just past the next rising edge, where inputs change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
      src_tvalid = 1'b1;
      src_tdata  = d;
      src_tkeep  = k;
      src_tlast  = l;
   endtask

   initial begin
      logic [7:0] le [4];
      logic [7:0] be [4];
      rst_n       = 1'b0;
      src_tvalid  = 1'b0;
      src_tdata   = '0;
      src_tkeep   = '0;
      src_tlast   = 1'b0;
      dest_tready = 1'b1;

      // Reset state
      repeat (2) tick();
      @(negedge clk);
      check_eq("rst_dvalid", d0.tvalid, 0);
      check_eq("rst_dlast", d0.tlast, 0);
      check_eq("rst_sready", s0.tready, 0);
      check_eq("rst_drop", drop0, 0);
      tick();
      rst_n = 1'b1;
      #1;
      check_eq("rel_sready", s0.tready, 1);

      // Full beat, both endiannesses
      le = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      be = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      drive(32'hDDCCBBAA, 4'b1111, 1'b1);
      @(negedge clk);
      check_eq("t1_accept", s0.tready, 1);
      tick();
      src_tvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq($sformatf("t1_valid%0d", k), d0.tvalid, 1);
         check_eq($sformatf("t1_data%0d", k), d0.tdata, le[k]);
         check_eq($sformatf("t1_last%0d", k), d0.tlast, (k == 3) ? 1 : 0);
         check_eq($sformatf("t1_sready%0d", k), s0.tready, (k == 3) ? 1 : 0);
         check_eq($sformatf("t2_data%0d", k), d1.tdata, be[k]);
         check_eq($sformatf("t2_last%0d", k), d1.tlast, (k == 3) ? 1 : 0);
         tick();
      end

      // Sparse keep 1010
      drive(32'h44332211, 4'b1010, 1'b1);
      @(negedge clk);
      check_eq("t3_accept", s0.tready, 1);
      tick();
      src_tvalid = 1'b0;
      @(negedge clk);
      check_eq("t3_data0", d0.tdata, 8'h22);
      check_eq("t3_last0", d0.tlast, 0);
      check_eq("t3_sready0", s0.tready, 0);
      check_eq("t3_be_data0", d1.tdata, 8'h44);
      tick();
      @(negedge clk);
      check_eq("t3_valid1", d0.tvalid, 1);
      check_eq("t3_data1", d0.tdata, 8'h44);
      check_eq("t3_last1", d0.tlast, 1);
      check_eq("t3_sready1", s0.tready, 1);
      check_eq("t3_be_data1", d1.tdata, 8'h22);
      check_eq("t3_be_last1", d1.tlast, 1);
      tick();

      // Zero-keep beats
      drive(32'h12345678, 4'b0000, 1'b0);
      @(negedge clk);
      check_eq("t4a_accept", s0.tready, 1);
      tick();
      src_tvalid = 1'b0;
      @(negedge clk);
      check_eq("t4a_dvalid", d0.tvalid, 0);
      check_eq("t4a_sready", s0.tready, 1);
      check_eq("t4a_drop", drop0, 0);
      tick();
      drive(32'h9ABCDEF0, 4'b0000, 1'b1);
      tick();
      src_tvalid = 1'b0;
      @(negedge clk);
      check_eq("t4b_drop", drop0, 1);
      check_eq("t4b_dvalid", d0.tvalid, 0);
      check_eq("t4b_sready", s0.tready, 1);
      tick();
      @(negedge clk);
      check_eq("t4b_drop_off", drop0, 0);
      tick();

      // Back-to-back beats, no gap
      drive(32'h04030201, 4'b1111, 1'b0);
      tick();
      drive(32'h08070605, 4'b1111, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq($sformatf("t5_valid%0d", k), d0.tvalid, 1);
         check_eq($sformatf("t5_data%0d", k), d0.tdata, 32'(k + 1));
         check_eq($sformatf("t5_last%0d", k), d0.tlast, (k == 7) ? 1 : 0);
         check_eq($sformatf("t5_sready%0d", k), s0.tready, (k == 3 || k == 7) ? 1 : 0);
         tick();
         if (k == 3) src_tvalid = 1'b0;
      end

      // Stall mid-beat
      drive(32'h14131211, 4'b1111, 1'b1);
      tick();
      src_tvalid = 1'b0;
      @(negedge clk);
      check_eq("t5s_data0", d0.tdata, 8'h11);
      tick();
      dest_tready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq($sformatf("t5s_hold_valid%0d", k), d0.tvalid, 1);
         check_eq($sformatf("t5s_hold_data%0d", k), d0.tdata, 8'h12);
         check_eq($sformatf("t5s_hold_last%0d", k), d0.tlast, 0);
         check_eq($sformatf("t5s_hold_sready%0d", k), s0.tready, 0);
         tick();
      end
      dest_tready = 1'b1;
      @(negedge clk);
      check_eq("t5s_data1", d0.tdata, 8'h12);
      tick();
      @(negedge clk);
      check_eq("t5s_data2", d0.tdata, 8'h13);
      tick();
      @(negedge clk);
      check_eq("t5s_data3", d0.tdata, 8'h14);
      check_eq("t5s_last3", d0.tlast, 1);
      tick();

      // Reset mid-beat, then a fresh partial beat
      drive(32'h55667788, 4'b1111, 1'b1);
      tick();
      src_tvalid = 1'b0;
      @(negedge clk);
      check_eq("t6_data0", d0.tdata, 8'h88);
      tick();
      @(negedge clk);
      check_eq("t6_data1", d0.tdata, 8'h77);
      tick();
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_dvalid", d0.tvalid, 0);
      check_eq("t6_rst_sready", s0.tready, 0);
      check_eq("t6_rst_be_dvalid", d1.tvalid, 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("t6_rel_dvalid", d0.tvalid, 0);
      check_eq("t6_rel_sready", s0.tready, 1);
      tick();
      drive(32'hA0B0C0D0, 4'b0011, 1'b1);
      tick();
      src_tvalid = 1'b0;
      @(negedge clk);
      check_eq("t6_new_data0", d0.tdata, 8'hD0);
      check_eq("t6_new_last0", d0.tlast, 0);
      check_eq("t6_new_be_data0", d1.tdata, 8'hC0);
      tick();
      @(negedge clk);
      check_eq("t6_new_data1", d0.tdata, 8'hC0);
      check_eq("t6_new_last1", d0.tlast, 1);
      check_eq("t6_new_be_data1", d1.tdata, 8'hD0);
      check_eq("t6_new_be_last1", d1.tlast, 1);
      tick();
      @(negedge clk);
      check_eq("t6_idle_dvalid", d0.tvalid, 0);
      check_eq("t6_idle_be_dvalid", d1.tvalid, 0);
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
